insn_byte_queue: RTL and testbench

- Instruction byte queue between the prefetch unit (write side) and the decoder/immediate reader (read side).
- Buffers the prefetched instruction stream as bytes.
- Read side pops one byte, or one little-endian 16-bit word, per cycle.
- `full` asserts early enough that the prefetcher's two-byte burst (fetch ack followed by the second byte on the next cycle) always fits.
- `flush` empties the queue when a new IP is loaded.

---
 rtl/insn_byte_queue.sv | 154 +++++++++++++++
 tb/tb_insn_byte_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/insn_byte_queue.sv
// Instruction byte queue between the prefetch unit (write side) and the
// decoder / immediate reader (read side). The read side can pop one byte or one
// little-endian 16-bit word per cycle. `full` asserts with enough slack for the
// prefetcher's two-byte burst. `flush` clears the queue when a new IP is loaded.
//
// Handshake: wr_en, rd_en and rd_word_en are single-cycle strobes with no
// ready return. The prefetcher throttles itself on the registered `full`
// flag. A push that still finds no room is dropped and latches `overflow`.
// A pop request on an empty queue (or a word pop with only one byte present)
// pops only what is available. The read outputs always show the current head
// and are qualified by `empty` / `word_valid`.
module insn_byte_queue #(
    parameter int DEPTH      = 6,
    parameter int FULL_SLACK = 2,
    parameter int COUNT_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic               full,
    input  logic               rd_en,
    input  logic               rd_word_en,
    output logic [7:0]         rd_data,
    output logic [15:0]        rd_word,
    output logic               empty,
    output logic               word_valid,
    output logic [COUNT_W-1:0] count,
    output logic               overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_X = COUNT_W + 1;

    localparam logic [CNT_X-1:0] DEPTH_X = CNT_X'(DEPTH);
    localparam logic [CNT_X-1:0] SLACK_X = CNT_X'(FULL_SLACK);
    localparam logic [CNT_X-1:0] ONE_X   = CNT_X'(1);
    localparam logic [CNT_X-1:0] TWO_X   = CNT_X'(2);
    localparam logic [PTR_W:0]   DEPTH_P = (PTR_W + 1)'(DEPTH);

    // Pointer increment by 0..2, wrapping modulo DEPTH (DEPTH need not be a
    // power of two, so a plain binary wrap is not enough).
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                 input logic [1:0]       inc);
        logic [PTR_W:0] sum;
        sum = {1'b0, ptr} + (PTR_W + 1)'(inc);
        if (sum >= DEPTH_P) begin
            sum = sum - DEPTH_P;
        end
        return sum[PTR_W-1:0];
    endfunction

    // State
    logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [COUNT_W-1:0] count_q,    count_d;
    logic               full_q,     full_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         mem_d [DEPTH];

    // Per-cycle decision signals
    logic [CNT_X-1:0] count_x;
    logic [1:0]       pop_amt;
    logic [CNT_X-1:0] after_pop_x;
    logic             push_ok;
    logic             push_rej;
    logic [CNT_X-1:0] count_next_x;
    logic [PTR_W-1:0] head_nxt;

    // Pop amount, push acceptance and the resulting occupancy.
    always_comb begin
        count_x = {1'b0, count_q};
        pop_amt = 2'd0;
        if (rd_word_en && (count_x >= TWO_X)) begin
            pop_amt = 2'd2;
        end else if ((rd_en || rd_word_en) && (count_x >= ONE_X)) begin
            pop_amt = 2'd1;
        end
        after_pop_x  = count_x - CNT_X'(pop_amt);
        push_ok      = wr_en && (after_pop_x < DEPTH_X);
        push_rej     = wr_en && !push_ok;
        count_next_x = after_pop_x + CNT_X'(push_ok);
    end

    // Next pointers, count and flags; flush overrides the same-cycle push and pop.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            rd_ptr_d   = ptr_add(rd_ptr_q, pop_amt);
            wr_ptr_d   = ptr_add(wr_ptr_q, {1'b0, push_ok});
            count_d    = count_next_x[COUNT_W-1:0];
            overflow_d = overflow_q | push_rej;
        end
        full_d = (DEPTH_X - {1'b0, count_d}) < SLACK_X;
    end

    // Storage write of an accepted push.
    always_comb begin
        mem_d = mem_q;
        if (!flush && push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
        end
    end

    // Control registers, asynchronously reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Byte storage; contents are not reset, occupancy alone decides validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Read side: head byte and little-endian head word, no write bypass.
    always_comb begin
        head_nxt   = ptr_add(rd_ptr_q, 2'd1);
        empty      = (count_q == '0);
        word_valid = ({1'b0, count_q} >= TWO_X);
        rd_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
        rd_word    = word_valid ? {mem_q[head_nxt], mem_q[rd_ptr_q]} : 16'h0000;
        count      = count_q;
        full       = full_q;
        overflow   = overflow_q;
    end

    param_check: assert property (@(posedge clk) (DEPTH >= 2) && (FULL_SLACK <= DEPTH));

    count_bound: assert property (@(posedge clk) disable iff (!reset_n)
                                  count_next_x <= DEPTH_X);

endmodule

// File: tb/tb_insn_byte_queue.sv
// Bench for insn_byte_queue: directed scenarios followed by random traffic,
// all compared against a byte-queue model of the intended behaviour.
module tb_insn_byte_queue;

    localparam int DEPTH      = 6;
    localparam int FULL_SLACK = 2;
    localparam int COUNT_W    = $clog2(DEPTH + 1);

    logic               clk;
    logic               reset_n;
    logic               flush;
    logic               wr_en;
    logic [7:0]         wr_data;
    logic               full;
    logic               rd_en;
    logic               rd_word_en;
    logic [7:0]         rd_data;
    logic [15:0]        rd_word;
    logic               empty;
    logic               word_valid;
    logic [COUNT_W-1:0] count;
    logic               overflow;

    int n_checks;
    int n_errors;

    // Reference model: the queued bytes in order plus the sticky overflow bit.
    logic [7:0] exp_q[$];
    logic       exp_ovf;

    insn_byte_queue #(
        .DEPTH      (DEPTH),
        .FULL_SLACK (FULL_SLACK)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .rd_en      (rd_en),
        .rd_word_en (rd_word_en),
        .rd_data    (rd_data),
        .rd_word    (rd_word),
        .empty      (empty),
        .word_valid (word_valid),
        .count      (count),
        .overflow   (overflow)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against the model's view of the queue.
    task automatic check_outputs(input string tag);
        int n;
        logic [7:0]  e_data;
        logic [15:0] e_word;
        n = exp_q.size();
        e_data = (n >= 1) ? exp_q[0] : 8'h00;
        e_word = (n >= 2) ? {exp_q[1], exp_q[0]} : 16'h0000;
        check({tag, ".count"},      32'(count),      32'(n));
        check({tag, ".empty"},      32'(empty),      32'(n == 0));
        check({tag, ".word_valid"}, 32'(word_valid), 32'(n >= 2));
        check({tag, ".full"},       32'(full),       32'((DEPTH - n) < FULL_SLACK));
        check({tag, ".overflow"},   32'(overflow),   32'(exp_ovf));
        check({tag, ".rd_data"},    32'(rd_data),    32'(e_data));
        check({tag, ".rd_word"},    32'(rd_word),    32'(e_word));
    endtask

    // Model of one clock edge: flush wins, then pops, then the push if room.
    task automatic model_update(input logic f, input logic w, input logic [7:0] d,
                                input logic r, input logic rw);
        int pops;
        if (f) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            pops = 0;
            if (rw && exp_q.size() >= 2) pops = 2;
            else if ((r || rw) && exp_q.size() >= 1) pops = 1;
            repeat (pops) void'(exp_q.pop_front());
            if (w) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(d);
                else exp_ovf = 1'b1;
            end
        end
    endtask

    // One cycle: apply inputs, check state before the edge, then advance the model.
    task automatic step(input string tag, input logic f, input logic w, input logic [7:0] d,
                        input logic r, input logic rw);
        flush = f; wr_en = w; wr_data = d; rd_en = r; rd_word_en = rw;
        check_outputs(tag);
        @(posedge clk);
        model_update(f, w, d, r, rw);
        #1;
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; rd_word_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 4 * DEPTH) begin
            step(tag, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            guard++;
        end
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        rd_en = 1'b0; rd_word_en = 1'b0;
        n_checks = 0; n_errors = 0; exp_ovf = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check_outputs("reset");

        // Reset mid-operation, asserted between clock edges.
        for (int i = 0; i < 3; i++) step("rst_push", 1'b0, 1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        exp_q.delete(); exp_ovf = 1'b0;
        check_outputs("async_rst");
        @(posedge clk);
        #1 reset_n = 1'b1;
        step("rst_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step("rst_wpop", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_outputs("rst_after");

        // Fill to full, then one extra push overflows.
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b0, 1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
        check_outputs("filled");
        step("over_push", 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        check_outputs("overflowed");
        check("ovf_set", 32'(overflow), 32'd1);
        drain("fill_drain");
        step("flush_ovf", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_outputs("ovf_cleared");

        // Word pop across the wrap point.
        for (int i = 0; i < DEPTH; i++) step("wrap_fill", 1'b0, 1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("wrap_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step("wrap_aa", 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        step("wrap_bb", 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0);
        check("wrap_word", 32'(rd_word), {16'h0, 8'hAA, 8'h25});
        step("wrap_wpop", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_outputs("wrap_after");
        step("wrap_last", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_outputs("wrap_single");

        // Simultaneous push and pop at full, and at count 2 with a word pop.
        for (int i = 0; i < DEPTH; i++) step("sim_fill", 1'b0, 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        step("sim_full_rw", 1'b0, 1'b1, 8'h3F, 1'b1, 1'b0);
        check_outputs("sim_full_after");
        drain("sim_drain");
        step("sim2_a", 1'b0, 1'b1, 8'h41, 1'b0, 1'b0);
        step("sim2_b", 1'b0, 1'b1, 8'h42, 1'b0, 1'b0);
        step("sim2_rw", 1'b0, 1'b1, 8'h43, 1'b0, 1'b1);
        check("sim2_newbyte", 32'(rd_data), 32'h43);
        check_outputs("sim2_after");
        drain("sim2_drain");

        // Flush beats a same-cycle push and pop.
        for (int i = 0; i < 4; i++) step("fl_fill", 1'b0, 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        step("fl_all", 1'b1, 1'b1, 8'h6F, 1'b1, 1'b0);
        check_outputs("fl_after");
        check("fl_empty", 32'(empty), 32'd1);

        // Prefetch burst pattern gated on full.
        for (int b = 0; b < 8; b++) begin
            if (!full) begin
                step("burst_a", 1'b0, 1'b1, 8'h80 + 8'(2 * b), 1'b0, 1'b0);
                step("burst_b", 1'b0, 1'b1, 8'h81 + 8'(2 * b), 1'b0, 1'b0);
            end else begin
                step("burst_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            end
        end
        check("burst_count", 32'(count), 32'(DEPTH));
        check("burst_no_ovf", 32'(overflow), 32'd0);
        drain("burst_drain");

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step("rand",
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 99) < 60),
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 25));
        end
        check_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
